// File: rtl/mips_mon_pkg.sv
// Shared types and defaults for the MIPS run monitor.
package mips_mon_pkg;

  localparam int unsigned MON_ADDR_W    = 32;
  localparam int unsigned MON_DATA_W    = 32;
  localparam int unsigned DEF_PASS_ADDR = 84;
  localparam int unsigned DEF_PASS_DATA = 7;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } mon_state_e;

  typedef struct packed {
    logic [MON_ADDR_W-1:0] addr;
    logic [MON_DATA_W-1:0] data;
  } log_entry_t;

endpackage

// File: rtl/mon_log_fifo.sv
// Store-log FIFO: overwrites the oldest entry when pushed while full and flags it stickily.
module mon_log_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             ovf_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             ovf_q;
  logic             full_c, pop_c, drop_c;

  assign valid_o = (cnt_q != '0);
  assign data_o  = valid_o ? mem_q[rd_q] : '0;
  assign ovf_o   = ovf_q;
  assign full_c  = (cnt_q == CW'(DEPTH));
  assign pop_c   = valid_o && pop_i;
  // Full with no pop: advance the read side past the entry being overwritten.
  assign drop_c  = push_i && full_c && !pop_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_c || drop_c) rd_q <= rd_q + AW'(1);
      if (push_i && !pop_c && !drop_c) cnt_q <= cnt_q + CW'(1);
      else if (!push_i && pop_c) cnt_q <= cnt_q - CW'(1);
      if (drop_c) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/mips_run_monitor.sv
// Run controller for MIPS top simulations: sequences cpu reset, watches stores, reports pass/fail/timeout.
// Optional store log enabled by defining MON_WRITE_LOG_EN.
module mips_run_monitor
  import mips_mon_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned RST_CYCLES = 3,
  parameter int unsigned MAX_CYCLES = 100,
  parameter int unsigned PASS_ADDR  = DEF_PASS_ADDR,
  parameter int unsigned PASS_DATA  = DEF_PASS_DATA,
  parameter int unsigned LOG_DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  output logic              cpu_reset,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  write_count,
  output logic              log_valid,
  input  logic              log_ready,
  output logic [ADDR_W-1:0] log_addr,
  output logic [DATA_W-1:0] log_data,
  output logic              log_ovf
);

  localparam int unsigned       HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [ADDR_W-1:0] SIG_ADDR  = ADDR_W'(PASS_ADDR);
  localparam logic [DATA_W-1:0] SIG_DATA  = DATA_W'(PASS_DATA);
  localparam logic [CNT_W-1:0]  CYC_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  mon_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              pass_q, pass_d, fail_q, fail_d, timeout_q, timeout_d, done_q, done_d;
  logic              addr_hit_c, data_hit_c;

  assign addr_hit_c = memwrite && (dataadr == SIG_ADDR);
  assign data_hit_c = (writedata == SIG_DATA);

  // Next state; signature store takes priority over the final budget cycle.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cycle_d = cycle_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = ST_RUN;
        else                     hold_d  = hold_q + HOLD_W'(1);
      end
      ST_RUN: begin
        if (cycle_q != CNT_MAX) cycle_d = cycle_q + CNT_W'(1);
        if (memwrite && (wcnt_q != CNT_MAX)) wcnt_d = wcnt_q + CNT_W'(1);
        if (addr_hit_c)               state_d = data_hit_c ? ST_PASS : ST_FAIL;
        else if (cycle_q == CYC_LAST) state_d = ST_TIMEOUT;
      end
      default: ;
    endcase
    cpu_reset_d = (state_d != ST_RUN);
    pass_d      = (state_d == ST_PASS);
    fail_d      = (state_d == ST_FAIL);
    timeout_d   = (state_d == ST_TIMEOUT);
    done_d      = pass_d || fail_d || timeout_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_HOLD;
      hold_q      <= '0;
      cycle_q     <= '0;
      wcnt_q      <= '0;
      cpu_reset_q <= 1'b1;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cycle_q     <= cycle_d;
      wcnt_q      <= wcnt_d;
      cpu_reset_q <= cpu_reset_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      done_q      <= done_d;
    end
  end

  assign cpu_reset   = cpu_reset_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign done        = done_q;
  assign cycle_count = cycle_q;
  assign write_count = wcnt_q;

`ifdef MON_WRITE_LOG_EN
  logic                     log_push_c;
  logic [ADDR_W+DATA_W-1:0] log_entry_c;

  assign log_push_c = (state_q == ST_RUN) && memwrite;

  mon_log_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (LOG_DEPTH)
  ) u_log_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (log_push_c),
    .data_i  ({dataadr, writedata}),
    .pop_i   (log_ready),
    .valid_o (log_valid),
    .data_o  (log_entry_c),
    .ovf_o   (log_ovf)
  );

  assign {log_addr, log_data} = log_entry_c;
`else
  logic unused_log_c;

  assign unused_log_c = ^{log_ready, 32'(LOG_DEPTH)};
  assign log_valid    = 1'b0;
  assign log_addr     = '0;
  assign log_data     = '0;
  assign log_ovf      = 1'b0;
`endif

endmodule

// File: doc/mips_run_monitor.md
Name: mips_run_monitor

Overview:
Parametrised run controller and store monitor for single-cycle/multicycle MIPS `top` simulations. It replaces hard-coded delay-based reset and fixed-time finish with a cycle-accurate sequence:
- sequences the core's reset;
- watches the data-memory write bus;
- declares pass/fail on a configurable signature store, or timeout after a cycle budget.

It sits beside `top`, driving its reset and observing `memwrite`/`dataadr`/`writedata`.

Parameters:
DATA_W, 32, width of writedata
ADDR_W, 32, width of dataadr
CNT_W, 16, width of cycle and write counters
RST_CYCLES, 3, cycles cpu_reset held high after monitor reset release (min 1)
MAX_CYCLES, 100, RUN-state cycle budget before timeout (must be < 2^CNT_W)
PASS_ADDR, 84, signature store address
PASS_DATA, 7, signature store value
LOG_DEPTH, 8, write-log entries (power of 2, ≥2; used only with log feature)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low monitor reset
memwrite  input  1  core data-memory write strobe
dataadr  input  ADDR_W  core data address
writedata  input  DATA_W  core store data
cpu_reset  output  1  active-high reset driven to top
done  output  1  run finished (any terminal state)
pass  output  1  signature store seen with PASS_DATA
fail  output  1  store to PASS_ADDR with other data
timeout  output  1  cycle budget exhausted
cycle_count  output  CNT_W  cycles spent in RUN
write_count  output  CNT_W  stores observed in RUN
log_valid  output  1  write-log entry available
log_ready  input  1  consumer accepts entry
log_addr  output  ADDR_W  logged address
log_data  output  DATA_W  logged data
log_ovf  output  1  sticky: log entry dropped

Behaviour:
- Reset low (asynchronous): state=HOLD, hold counter=0, cpu_reset=1, done/pass/fail/timeout=0, both counters=0, log empty, log_valid=0, log_ovf=0, log_addr/log_data=0.
- States:
  - HOLD: cpu_reset=1; hold counter increments each cycle; on the cycle it reaches RST_CYCLES-1 → RUN. cpu_reset is therefore low exactly RST_CYCLES clocks after reset rises.
  - RUN: cpu_reset=0; cycle_count += 1 per cycle, saturating at all-ones. memwrite sampled only in RUN; strobes in HOLD or terminal states are ignored.
    - memwrite & dataadr==PASS_ADDR & writedata==PASS_DATA → PASS.
    - memwrite & dataadr==PASS_ADDR & writedata!=PASS_DATA → FAIL.
    - Else if cycle_count==MAX_CYCLES-1 → TIMEOUT.
  - PASS / FAIL / TIMEOUT: terminal and sticky until reset.
- Same-cycle priority: a signature store wins over timeout on the final budget cycle.
- Flags: pass/fail/timeout registered, asserted the cycle after the triggering edge. done = OR of the three; exactly one is ever set.
- Core frozen on finish: cpu_reset returns to 1 in all terminal states.
- write_count: +1 per RUN-state memwrite, including the signature store; saturates at all-ones.
- Counters freeze in terminal states.
- Reset asserted mid-run: immediate return to HOLD with all outputs at reset values.
- Widths: address/data comparisons use the full ADDR_W/DATA_W. Parameters are truncated to those widths.

Optional Feature:
Macro MON_WRITE_LOG_EN.
- Defined:
  - Every RUN-state store pushes {dataadr, writedata} into a LOG_DEPTH FIFO.
  - log_valid=1 whenever the FIFO is non-empty; log_addr/log_data show the oldest entry. An entry pops on log_valid & log_ready.
  - Push when full with no pop: the oldest entry is discarded, the new one is stored, and log_ovf sets (sticky).
  - Push and pop in the same cycle when full: no drop, no ovf. Same cycle when empty: the entry is stored and log_valid rises the next cycle (no bypass).
- Undefined: no FIFO storage; log_valid, log_addr, log_data, log_ovf tied 0; log_ready ignored. Ports remain present.

Decomposition:
- Package mips_mon_pkg holds:
  - state enum (HOLD, RUN, PASS, FAIL, TIMEOUT), 3-bit encoding;
  - default PASS_ADDR/PASS_DATA constants;
  - log-entry struct {addr, data}.
- One sub-module: mon_log_fifo (parametrised width/depth, overwrite-on-full, ovf flag), instantiated only under MON_WRITE_LOG_EN.

Test Plan:
- Reset low 2 cycles, release, RST_CYCLES=3 → cpu_reset falls exactly 3 rising edges after release; counters stay 0 during HOLD.
- In RUN, store 7 to 84 at cycle 20 → pass=1 the next cycle, done=1, cpu_reset=1, cycle_count frozen at 21, write_count=1; later stores ignored.
- Store 5 to 84 → fail=1 only; pass=0.
- No stores, MAX_CYCLES=100 → timeout=1 after 100 RUN cycles; signature store on cycle 99 yields pass, not timeout.
- Assert reset while in RUN at cycle 40 → all outputs to reset values asynchronously; a fresh run completes normally.
- MON_WRITE_LOG_EN, LOG_DEPTH=8, log_ready=0, 10 stores → log_ovf=1; draining yields entries 3..10 in order; push+pop while full keeps log_ovf unchanged.
